// File: rtl/clos_bank_adapter.sv
// clos_bank_adapter: unpacks a Clos egress request stream onto one SRAM bank and returns fixed-latency responses.
// Ports:
//   clk_i, rst_i           clock, asynchronous active-high reset
//   req_i, wdata_i, gnt_o  egress request, packed payload {wen, be, addr, data}, grant
//   stall_i                bank busy this cycle (blocks the grant)
//   rdata_o, resp_vld_o    response data and response strobe, MemLatency cycles after grant
//   bank_*                 SRAM chip select, write enable, address, byte enables, write/read data
//   stall_cnt_o            saturating count of cycles with req_i & stall_i
module clos_bank_adapter #(
  parameter int AddrWidth    = 10,
  parameter int DataWidth    = 32,
  parameter int BeWidth      = DataWidth / 8,
  parameter int ReqDataWidth = 1 + BeWidth + AddrWidth + DataWidth,
  parameter int MemLatency   = 2,
  parameter int BankLatency  = 1,
  parameter int ReqReg       = 0,
  parameter int CntWidth     = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_i,
  input  logic [ReqDataWidth-1:0] wdata_i,
  output logic                    gnt_o,
  output logic [DataWidth-1:0]    rdata_o,
  input  logic                    stall_i,
  output logic                    bank_req_o,
  output logic                    bank_we_o,
  output logic [AddrWidth-1:0]    bank_addr_o,
  output logic [BeWidth-1:0]      bank_be_o,
  output logic [DataWidth-1:0]    bank_wdata_o,
  input  logic [DataWidth-1:0]    bank_rdata_i,
  output logic                    resp_vld_o,
  output logic [CntWidth-1:0]     stall_cnt_o
);
  localparam int D   = MemLatency - BankLatency - ReqReg;
  localparam int Cap = ReqReg + BankLatency;
  localparam int PW  = BeWidth + AddrWidth + DataWidth;

  if (ReqDataWidth != 1 + BeWidth + AddrWidth + DataWidth) begin : g_bad_width
    $fatal(1, "clos_bank_adapter: ReqDataWidth does not match 1+BeWidth+AddrWidth+DataWidth");
  end
  if (BankLatency < 1 || BankLatency > MemLatency - ReqReg || MemLatency > 8) begin : g_bad_lat
    $fatal(1, "clos_bank_adapter: latency parameters out of range");
  end

  logic          gnt;
  logic          wen;
  logic [PW-1:0] pay;

  assign gnt   = req_i & ~stall_i;
  assign gnt_o = gnt;
  assign wen   = wdata_i[ReqDataWidth-1];
  assign pay   = wdata_i[ReqDataWidth-2:0];

  // The hold register keeps addr/be/wdata stable whenever the bank is idle.
  if (ReqReg != 0) begin : g_reg
    logic          req_q;
    logic          we_q;
    logic [PW-1:0] hold;
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        req_q <= 1'b0;
        we_q  <= 1'b0;
        hold  <= '0;
      end else begin
        req_q <= gnt;
        we_q  <= gnt & wen;
        if (gnt) hold <= pay;
      end
    end
    assign bank_req_o = req_q;
    assign bank_we_o  = we_q;
    assign {bank_be_o, bank_addr_o, bank_wdata_o} = hold;
  end else begin : g_comb
    logic [PW-1:0] hold;
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) hold <= '0;
      else if (gnt) hold <= pay;
    end
    assign bank_req_o = gnt;
    assign bank_we_o  = gnt & wen;
    assign {bank_be_o, bank_addr_o, bank_wdata_o} = gnt ? pay : hold;
  end

  // Bit k of v/r describes the request granted k cycles ago; r is valid-and-read.
  logic [MemLatency:1] vq;
  logic [MemLatency:1] rq;
  logic [MemLatency:0] v;
  logic [MemLatency:0] r;

  assign v = {vq, gnt};
  assign r = {rq, gnt & ~wen};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vq <= '0;
      rq <= '0;
    end else begin
      vq <= v[MemLatency-1:0];
      rq <= r[MemLatency-1:0];
    end
  end

  // Read data appears on the bank at stage Cap and is retimed D times to reach stage MemLatency.
  logic [DataWidth-1:0] dp [0:D];
  logic [DataWidth-1:0] hold_rd;

  assign dp[0] = bank_rdata_i;

  for (genvar k = 1; k <= D; k++) begin : g_ret
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) dp[k] <= '0;
      else if (r[Cap+k-1]) dp[k] <= dp[k-1];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) hold_rd <= '0;
    else if (r[MemLatency]) hold_rd <= dp[D];
  end

  assign resp_vld_o = v[MemLatency];
  assign rdata_o    = r[MemLatency] ? dp[D] : hold_rd;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) stall_cnt_o <= '0;
    else if (req_i & stall_i & ~&stall_cnt_o) stall_cnt_o <= stall_cnt_o + CntWidth'(1);
  end
endmodule

// File: tb/tb_clos_bank_adapter.sv
// tb_clos_bank_adapter: scoreboard bench for two clos_bank_adapter configurations sharing one stimulus stream.
module tb_clos_bank_adapter;
  logic        clk = 0;
  logic        rst = 1;
  logic        req = 0;
  logic        stall = 0;
  logic        wen = 0;
  logic [3:0]  be = 0;
  logic [9:0]  addr = 0;
  logic [31:0] data = 0;
  logic [46:0] payload;
  assign payload = {wen, be, addr, data};

  always #5 clk = ~clk;

  logic        gnt0, breq0, bwe0, vld0;
  logic [31:0] rdata0, bwd0, brd0;
  logic [9:0]  baddr0;
  logic [3:0]  bbe0;
  logic [15:0] cnt0;
  logic        gnt1, breq1, bwe1, vld1;
  logic [31:0] rdata1, bwd1, brd1;
  logic [9:0]  baddr1;
  logic [3:0]  bbe1;
  logic [3:0]  cnt1;

  clos_bank_adapter dut0 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .wdata_i(payload), .gnt_o(gnt0), .rdata_o(rdata0),
    .stall_i(stall), .bank_req_o(breq0), .bank_we_o(bwe0), .bank_addr_o(baddr0), .bank_be_o(bbe0),
    .bank_wdata_o(bwd0), .bank_rdata_i(brd0), .resp_vld_o(vld0), .stall_cnt_o(cnt0)
  );

  clos_bank_adapter #(.MemLatency(4), .BankLatency(2), .ReqReg(1), .CntWidth(4)) dut1 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .wdata_i(payload), .gnt_o(gnt1), .rdata_o(rdata1),
    .stall_i(stall), .bank_req_o(breq1), .bank_we_o(bwe1), .bank_addr_o(baddr1), .bank_be_o(bbe1),
    .bank_wdata_o(bwd1), .bank_rdata_i(brd1), .resp_vld_o(vld1), .stall_cnt_o(cnt1)
  );

  // SRAM bank models: BankLatency 1 for dut0, 2 for dut1.
  logic [31:0] m0 [1024];
  logic [31:0] m1 [1024];
  logic [31:0] mref [1024];
  logic [31:0] b1a;

  always @(posedge clk) begin
    if (breq0) begin
      if (bwe0) begin
        for (int i = 0; i < 4; i++) if (bbe0[i]) m0[baddr0][8*i +: 8] <= bwd0[8*i +: 8];
      end else brd0 <= m0[baddr0];
    end
    if (breq1) begin
      if (bwe1) begin
        for (int i = 0; i < 4; i++) if (bbe1[i]) m1[baddr1][8*i +: 8] <= bwd1[8*i +: 8];
      end else b1a <= m1[baddr1];
    end
    brd1 <= b1a;
  end

  typedef struct {
    int          due;
    logic        rd;
    logic [31:0] d;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] l0 = 0;
  logic [31:0] l1 = 0;
  int          sc0 = 0;
  int          sc1 = 0;
  logic        pg = 0;
  logic        pwe = 0;
  logic [9:0]  pad = 0;
  int          cyc = 0;
  int          n = 0;
  int          errs = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Reference model: grant rule plus an architectural memory updated in grant order.
  task automatic drive(input logic rq, input logic st, input logic w, input logic [3:0] b,
                       input logic [9:0] ad, input logic [31:0] d);
    exp_t e;
    @(posedge clk);
    #1;
    req = rq; stall = st; wen = w; be = b; addr = ad; data = d;
    if (rq && !st) begin
      e.rd = !w;
      e.d  = mref[ad];
      if (w) for (int i = 0; i < 4; i++) if (b[i]) mref[ad][8*i +: 8] = d[8*i +: 8];
      e.due = cyc + 2;
      q0.push_back(e);
      e.due = cyc + 4;
      q1.push_back(e);
    end
  endtask

  task automatic idle(input int k);
    repeat (k) drive(0, 0, 0, 4'h0, 10'h0, 32'h0);
  endtask

  task automatic do_reset(input int k);
    @(posedge clk);
    #1;
    rst = 1; req = 0; stall = 0;
    q0.delete(); q1.delete();
    l0 = 0; l1 = 0; sc0 = 0; sc1 = 0; pg = 0;
    repeat (k) @(posedge clk);
    #1;
    rst = 0;
  endtask

  always @(negedge clk) begin
    logic g;
    logic ev;
    exp_t e;
    g = req & ~stall;
    chk("gnt0", gnt0, g);
    chk("gnt1", gnt1, g);
    chk("bank_req0", breq0, g);
    if (g) begin
      chk("bank_we0", bwe0, wen);
      chk("bank_addr0", baddr0, addr);
      if (wen) begin
        chk("bank_be0", bbe0, be);
        chk("bank_wdata0", bwd0, data);
      end
    end
    chk("bank_req1", breq1, pg);
    if (pg) begin
      chk("bank_we1", bwe1, pwe);
      chk("bank_addr1", baddr1, pad);
    end
    pg = g; pwe = wen; pad = addr;
    ev = q0.size() > 0 && q0[0].due == cyc;
    if (ev) begin
      e = q0.pop_front();
      if (e.rd) l0 = e.d;
    end
    chk("resp_vld0", vld0, ev);
    chk("rdata0", rdata0, l0);
    ev = q1.size() > 0 && q1[0].due == cyc;
    if (ev) begin
      e = q1.pop_front();
      if (e.rd) l1 = e.d;
    end
    chk("resp_vld1", vld1, ev);
    chk("rdata1", rdata1, l1);
    chk("stall_cnt0", cnt0, sc0);
    chk("stall_cnt1", cnt1, sc1);
    if (req && stall) begin
      if (sc0 < 65535) sc0++;
      if (sc1 < 15) sc1++;
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++) mref[i] = $urandom;
    mref[5] = 32'hDEADBEEF;
    mref[1] = 32'h11;
    mref[2] = 32'h22;
    mref[3] = 32'h33;
    for (int i = 0; i < 1024; i++) begin
      m0[i] = mref[i];
      m1[i] = mref[i];
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    idle(1);
    drive(1, 0, 0, 4'hF, 10'd5, 32'h0);
    idle(4);
    drive(1, 0, 0, 4'hF, 10'd1, 32'h0);
    drive(1, 0, 0, 4'hF, 10'd2, 32'h0);
    drive(1, 0, 0, 4'hF, 10'd3, 32'h0);
    drive(1, 0, 1, 4'hF, 10'd4, 32'hAAAA);
    idle(6);
    repeat (3) drive(1, 1, 0, 4'hF, 10'd7, 32'h0);
    drive(1, 0, 0, 4'hF, 10'd7, 32'h0);
    idle(5);
    repeat (20) drive(1, 1, 0, 4'hF, 10'd8, 32'h0);
    idle(2);
    drive(1, 0, 0, 4'hF, 10'd9, 32'h0);
    do_reset(1);
    idle(8);
    repeat (1500)
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 4) == 0, 1'($urandom_range(0, 1)),
            4'($urandom), 10'($urandom_range(0, 15)), $urandom);
    idle(12);
    chk("drain0", 64'(q0.size()), 64'd0);
    chk("drain1", 64'(q1.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule
